voice_allocator: RTL and testbench

Polyphonic voice scheduler between note_decoder gate outputs and the shared sine BRAM read ports / phase accumulators. Tracks per-key gate edges and assigns sounding keys to a limited pool of voices (one BRAM port per voice). Drives the per-voice note index, active flag, start pulse and active-voice count consumed by address generation and the output mixer. Services at most one key event per cycle.

---
 rtl/voice_allocator.sv | 149 ++++++++++++++
 tb/tb_voice_allocator.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/voice_allocator.sv
// voice_allocator: assigns key gate events to a small pool of voices, one key event per cycle
// Ports:
//   clk_in, rst_in      clock, synchronous active-high reset
//   gate_in             level gate per key (bit i = key i held)
//   voice_note_out      packed key index per voice (holds last value when the voice is idle)
//   voice_active_out    voice sounding flags
//   voice_start_out     one-cycle phase-reset pulse when a voice takes a new key
//   num_voices_out      popcount of voice_active_out
//   busy_out            key events still pending
//   dropped_out         one-cycle pulse when a note-on is discarded
// Build option: VOICE_STEAL_EN makes a note-on with no free voice steal the oldest voice
module voice_allocator #(
  parameter int NUM_NOTES  = 8,
  parameter int NUM_VOICES = 2
) (
  input  logic                                    clk_in,
  input  logic                                    rst_in,
  input  logic [NUM_NOTES-1:0]                    gate_in,
  output logic [NUM_VOICES*$clog2(NUM_NOTES)-1:0] voice_note_out,
  output logic [NUM_VOICES-1:0]                   voice_active_out,
  output logic [NUM_VOICES-1:0]                   voice_start_out,
  output logic [$clog2(NUM_VOICES+1)-1:0]         num_voices_out,
  output logic                                    busy_out,
  output logic                                    dropped_out
);
  localparam int NOTE_W = $clog2(NUM_NOTES);
  localparam int CNT_W  = $clog2(NUM_VOICES+1);
  localparam int AGE_W  = NUM_VOICES > 1 ? $clog2(NUM_VOICES) : 1;
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(NUM_VOICES-1);
  logic [NUM_NOTES-1:0]  gate_q, pend_on_q, pend_on_d, pend_off_q, pend_off_d;
  logic [NUM_NOTES-1:0]  rise, fall, clr_on, clr_off;
  logic [NOTE_W-1:0]     note_q [NUM_VOICES];
  logic [NOTE_W-1:0]     note_d [NUM_VOICES];
  logic [AGE_W-1:0]      age_q  [NUM_VOICES];
  logic [AGE_W-1:0]      age_d  [NUM_VOICES];
  logic [NUM_VOICES-1:0] active_q, active_d, start_q, start_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  busy_q, busy_d, dropped_q, dropped_d;
  logic                  off_hit, on_hit, held, free_hit, do_assign;
  logic [NOTE_W-1:0]     off_k, on_k;
  logic [AGE_W-1:0]      free_v, tgt_v;
`ifdef VOICE_STEAL_EN
  logic [AGE_W-1:0]      old_v, old_age;
`endif
  always_comb begin
    rise = gate_in & ~gate_q;
    fall = ~gate_in & gate_q;
    off_hit = |pend_off_q;
    on_hit = |pend_on_q;
    off_k = '0;
    on_k = '0;
    for (int i = NUM_NOTES-1; i >= 0; i--) begin
      off_k = pend_off_q[i] ? NOTE_W'(i) : off_k;
      on_k = pend_on_q[i] ? NOTE_W'(i) : on_k;
    end
    free_hit = ~&active_q;
    free_v = '0;
    held = 1'b0;
    for (int v = NUM_VOICES-1; v >= 0; v--) begin
      free_v = active_q[v] ? free_v : AGE_W'(v);
      held = held | (active_q[v] && note_q[v] == on_k);
    end
`ifdef VOICE_STEAL_EN
    // strict compare keeps the lowest index on equal ages
    old_v = '0;
    old_age = age_q[0];
    for (int v = 1; v < NUM_VOICES; v++) begin
      old_v = age_q[v] > old_age ? AGE_W'(v) : old_v;
      old_age = age_q[v] > old_age ? age_q[v] : old_age;
    end
`endif
    note_d = note_q;
    age_d = age_q;
    active_d = active_q;
    start_d = '0;
    dropped_d = 1'b0;
    do_assign = 1'b0;
    tgt_v = free_v;
    clr_off = off_hit ? NUM_NOTES'(1) << off_k : '0;
    clr_on = (!off_hit && on_hit) ? NUM_NOTES'(1) << on_k : '0;
    if (off_hit) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (active_q[v] && note_q[v] == off_k) begin
          active_d[v] = 1'b0;
          age_d[v] = '0;
        end
      end
    end else if (on_hit && !held) begin
`ifdef VOICE_STEAL_EN
      do_assign = 1'b1;
      tgt_v = free_hit ? free_v : old_v;
`else
      do_assign = free_hit;
      dropped_d = !free_hit;
`endif
    end
    if (do_assign) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (AGE_W'(v) == tgt_v) begin
          note_d[v] = on_k;
          active_d[v] = 1'b1;
          start_d[v] = 1'b1;
          age_d[v] = '0;
        end else if (active_q[v]) begin
          age_d[v] = age_q[v] == AGE_MAX ? AGE_MAX : age_q[v] + 1'b1;
        end
      end
    end
    // a bit raised in the same cycle it is serviced stays pending
    pend_on_d = (pend_on_q & ~clr_on) | rise;
    pend_off_d = (pend_off_q & ~clr_off) | fall;
    busy_d = |(pend_on_d | pend_off_d);
    cnt_d = '0;
    for (int v = 0; v < NUM_VOICES; v++) cnt_d = cnt_d + CNT_W'(active_d[v]);
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      gate_q <= '0;
      pend_on_q <= '0;
      pend_off_q <= '0;
      note_q <= '{default: '0};
      age_q <= '{default: '0};
      active_q <= '0;
      start_q <= '0;
      cnt_q <= '0;
      busy_q <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      gate_q <= gate_in;
      pend_on_q <= pend_on_d;
      pend_off_q <= pend_off_d;
      note_q <= note_d;
      age_q <= age_d;
      active_q <= active_d;
      start_q <= start_d;
      cnt_q <= cnt_d;
      busy_q <= busy_d;
      dropped_q <= dropped_d;
    end
  end
  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_note
    assign voice_note_out[g*NOTE_W +: NOTE_W] = note_q[g];
  end
  assign voice_active_out = active_q;
  assign voice_start_out = start_q;
  assign num_voices_out = cnt_q;
  assign busy_out = busy_q;
  assign dropped_out = dropped_q;
endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator: directed checks of voice_allocator with hand-computed expectations
module tb_voice_allocator;
  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic [7:0] gate_in = '0;
  logic [5:0] voice_note_out;
  logic [1:0] voice_active_out, voice_start_out, num_voices_out;
  logic       busy_out, dropped_out;
  int n_chk = 0;
  int n_fail = 0;
  voice_allocator dut (
    .clk_in(clk_in), .rst_in(rst_in), .gate_in(gate_in),
    .voice_note_out(voice_note_out), .voice_active_out(voice_active_out),
    .voice_start_out(voice_start_out), .num_voices_out(num_voices_out),
    .busy_out(busy_out), .dropped_out(dropped_out)
  );
  always #5 clk_in = ~clk_in;
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk_in);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  initial begin
    step(2);
    rst_in = 1'b0;
    check("rst_active", voice_active_out, 0);
    check("rst_start", voice_start_out, 0);
    check("rst_cnt", num_voices_out, 0);
    check("rst_busy", busy_out, 0);
    check("rst_drop", dropped_out, 0);
    check("rst_notes", voice_note_out, 0);
    gate_in = 8'h04;
    step();
    check("k2_busy", busy_out, 1);
    check("k2_active_early", voice_active_out, 0);
    step();
    check("k2_note0", voice_note_out[2:0], 2);
    check("k2_active", voice_active_out, 2'b01);
    check("k2_start", voice_start_out, 2'b01);
    check("k2_cnt", num_voices_out, 1);
    check("k2_busy_done", busy_out, 0);
    step();
    check("k2_start_pulse", voice_start_out, 0);
    check("k2_hold", voice_active_out, 2'b01);
    gate_in = 8'h00;
    step();
    check("k2_off_early", voice_active_out, 2'b01);
    step();
    check("k2_off", voice_active_out, 0);
    check("k2_off_cnt", num_voices_out, 0);
    gate_in = 8'h81;
    step();
    check("sim_busy1", busy_out, 1);
    step();
    check("sim_note0", voice_note_out[2:0], 0);
    check("sim_active1", voice_active_out, 2'b01);
    check("sim_start1", voice_start_out, 2'b01);
    check("sim_busy2", busy_out, 1);
    step();
    check("sim_note1", voice_note_out[5:3], 7);
    check("sim_active2", voice_active_out, 2'b11);
    check("sim_start2", voice_start_out, 2'b10);
    check("sim_cnt", num_voices_out, 2);
    check("sim_busy_end", busy_out, 0);
    gate_in = 8'h00;
    step(3);
    check("sim_release", voice_active_out, 0);
    gate_in = 8'h02;
    step(2);
    gate_in = 8'h0A;
    step(2);
    check("ovf_setup_notes", voice_note_out, {3'd3, 3'd1});
    check("ovf_setup_active", voice_active_out, 2'b11);
    gate_in = 8'h2A;
    step(2);
`ifdef VOICE_STEAL_EN
    check("ovf_notes", voice_note_out, {3'd3, 3'd5});
    check("ovf_start", voice_start_out, 2'b01);
    check("ovf_drop", dropped_out, 0);
`else
    check("ovf_notes", voice_note_out, {3'd3, 3'd1});
    check("ovf_start", voice_start_out, 2'b00);
    check("ovf_drop", dropped_out, 1);
`endif
    check("ovf_active", voice_active_out, 2'b11);
    step();
    check("ovf_drop_pulse", dropped_out, 0);
    gate_in = 8'h0A;
    step(2);
`ifdef VOICE_STEAL_EN
    check("ovf_k5_off", voice_active_out, 2'b10);
`else
    check("ovf_k5_off", voice_active_out, 2'b11);
    check("ovf_k5_notes", voice_note_out, {3'd3, 3'd1});
`endif
    gate_in = 8'h00;
    step(3);
    check("ovf_release", voice_active_out, 0);
    gate_in = 8'h10;
    step(3);
    check("rt_setup", voice_active_out, 2'b01);
    gate_in = 8'h00;
    step();
    gate_in = 8'h10;
    step();
    check("rt_off", voice_active_out, 0);
    check("rt_off_start", voice_start_out, 0);
    step();
    check("rt_on", voice_active_out, 2'b01);
    check("rt_note", voice_note_out[2:0], 4);
    check("rt_start", voice_start_out, 2'b01);
    step();
    check("rt_start_pulse", voice_start_out, 0);
    gate_in = 8'h00;
    step(2);
    gate_in = 8'h03;
    step(3);
    check("mr_setup", voice_active_out, 2'b11);
    gate_in = 8'h0F;
    step();
    check("mr_busy", busy_out, 1);
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    check("mr_active", voice_active_out, 0);
    check("mr_cnt", num_voices_out, 0);
    check("mr_busy_clr", busy_out, 0);
    check("mr_notes", voice_note_out, 0);
    step(2);
    check("mr_re_note0", voice_note_out[2:0], 0);
    check("mr_re_active", voice_active_out, 2'b01);
    check("mr_re_start", voice_start_out, 2'b01);
    step();
    check("mr_re_note1", voice_note_out[5:3], 1);
    check("mr_re_cnt", num_voices_out, 2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
